// File: rtl/bch_encoder.sv
// bch_encoder: systematic BCH(63,51), t=2, serial in / serial out.
// Message bits are forwarded as they arrive (coefficient x^0 first), then the
// 12 parity bits p_0..p_11 are appended.
// Optional feature macro: BCH_ENC_LAST_EN adds the out_last frame marker.
module bch_encoder (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  input  logic in_data,
  output logic in_ready,
  output logic out_valid,
  output logic out_data,
`ifdef BCH_ENC_LAST_EN
  output logic out_last,
`endif
  input  logic out_ready
);

  // g(x) without the implicit x^12 term; also x^12 mod g, the weight of m_0
  localparam logic [11:0] GPOLY  = 12'h539;
  localparam logic [11:0] W_INIT = 12'h539;
  localparam logic [5:0]  MSG_LAST = 6'd50;
  localparam logic [3:0]  PAR_LAST = 4'd11;

  typedef enum logic {ST_MSG, ST_PARITY} state_t;

  state_t      state;
  logic [5:0]  msg_cnt;
  logic [3:0]  par_cnt;
  logic [11:0] r;     // parity accumulator: sum of m_i * x^(12+i) mod g
  logic [11:0] w;     // x^(12+i) mod g for the next message bit i
  logic        free;
  logic        in_xfer;

  // multiply by x modulo g
  function automatic logic [11:0] w_step(input logic [11:0] v);
    return {v[10:0], 1'b0} ^ (v[11] ? GPOLY : 12'h000);
  endfunction

  assign free     = !out_valid || out_ready;
  // gated by rst_n so the stream never appears ready while held in reset
  assign in_ready = rst_n && (state == ST_MSG) && free;
  assign in_xfer  = in_valid && in_ready;

  // frame FSM, parity accumulation and the single output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_MSG;
      msg_cnt   <= '0;
      par_cnt   <= '0;
      r         <= '0;
      w         <= W_INIT;
      out_valid <= 1'b0;
      out_data  <= 1'b0;
`ifdef BCH_ENC_LAST_EN
      out_last  <= 1'b0;
`endif
    end else begin
      case (state)
        ST_MSG: begin
          if (in_xfer) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
`ifdef BCH_ENC_LAST_EN
            out_last  <= 1'b0;
`endif
            if (in_data) r <= r ^ w;
            w <= w_step(w);
            if (msg_cnt == MSG_LAST) begin
              msg_cnt <= '0;
              state   <= ST_PARITY;
            end else begin
              msg_cnt <= msg_cnt + 6'd1;
            end
          end else if (free) begin
            out_valid <= 1'b0;
          end
        end
        ST_PARITY: begin
          // R and par_cnt only move when the output register can take a bit
          if (free) begin
            out_data  <= r[0];
            out_valid <= 1'b1;
            r         <= r >> 1;
`ifdef BCH_ENC_LAST_EN
            out_last  <= (par_cnt == PAR_LAST);
`endif
            if (par_cnt == PAR_LAST) begin
              par_cnt <= '0;
              r       <= '0;
              w       <= W_INIT;
              state   <= ST_MSG;
            end else begin
              par_cnt <= par_cnt + 4'd1;
            end
          end
        end
        default: state <= ST_MSG;
      endcase
    end
  end

endmodule

// File: tb/tb_bch_encoder.sv
// tb_bch_encoder: directed vector table plus throttled random frames and a
// mid-frame reset sequence for bch_encoder.
module tb_bch_encoder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_data = 1'b0;
  logic out_ready = 1'b0;
  logic in_ready, out_valid, out_data, out_last;

  always #5 clk = ~clk;

  bch_encoder dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .out_data(out_data),
`ifdef BCH_ENC_LAST_EN
    .out_last(out_last),
`endif
    .out_ready(out_ready)
  );
`ifndef BCH_ENC_LAST_EN
  assign out_last = 1'b0;
`endif

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // remainder of a degree<63 polynomial (bit i = coeff of x^i) modulo g
  function automatic logic [11:0] mod_g(input logic [62:0] d);
    logic [62:0] t;
    t = d;
    for (int deg = 62; deg >= 12; deg--)
      if (t[deg]) t[deg -: 13] = t[deg -: 13] ^ 13'h1539;
    return t[11:0];
  endfunction

  function automatic logic [11:0] par_of(input logic [50:0] m);
    return mod_g({m, 12'b0});
  endfunction

  typedef struct {
    string       name;
    logic [50:0] msg;
    logic [11:0] par;
  } vec_t;

  vec_t vt[5];

  // Drives one 51-bit message and collects 63 output bits. pin/pout are the
  // per-cycle percentages for in_valid and out_ready.
  task automatic run_frame(input logic [50:0] msg, input int pin, input int pout,
                           output logic [62:0] got, output logic [62:0] lastv,
                           output int span, output int rdy_low,
                           output logic rdy_end, output logic held_ok,
                           output logic done);
    int ni, no, cyc, first_acc;
    logic pend, hd;
    ni = 0; no = 0; cyc = 0; first_acc = -1;
    span = 0; rdy_low = 0; rdy_end = 1'b0; held_ok = 1'b1;
    got = '0; lastv = '0; pend = 1'b0; hd = 1'b0;
    while (no < 63 && cyc < 3000) begin
      @(negedge clk);
      if (pend && (!out_valid || out_data !== hd)) held_ok = 1'b0;
      in_valid  = (ni < 51) && ($urandom_range(99) < pin);
      in_data   = in_valid ? msg[ni] : 1'b0;
      out_ready = ($urandom_range(99) < pout);
      #1;
      if (!in_ready) rdy_low++;
      if (in_valid && in_ready) begin
        if (first_acc < 0) first_acc = cyc;
        ni++;
      end
      if (out_valid && out_ready) begin
        got[no]   = out_data;
        lastv[no] = out_last;
        no++;
        if (no == 63) begin
          span    = cyc - first_acc;
          rdy_end = in_ready;
        end
      end
      pend = out_valid && !out_ready;
      hd   = out_data;
      cyc++;
    end
    done = (no == 63);
  endtask

  initial begin
    logic [62:0] got, lastv;
    logic [50:0] msg;
    int span, rdy_low;
    logic rdy_end, held_ok, done;

    vt[0] = '{"zero",  51'h0, 12'h000};
    vt[1] = '{"bit0",  51'h1, 12'h539};
    vt[2] = '{"bit50", 51'h1 << 50, 12'hA9C};
    vt[3] = '{"bit1",  51'h2, 12'hA72};
    vt[4] = '{"bit01", 51'h3, 12'hF4B};

    // reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst out_data", 64'(out_data), 64'd0);
    chk("rst in_ready", 64'(in_ready), 64'd0);
    chk("rst out_last", 64'(out_last), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("in_ready after reset", 64'(in_ready), 64'd1);

    // directed vectors, no throttling
    for (int i = 0; i < 5; i++) begin
      run_frame(vt[i].msg, 100, 100, got, lastv, span, rdy_low, rdy_end, held_ok, done);
      chk({vt[i].name, " done"}, 64'(done), 64'd1);
      chk({vt[i].name, " msg"}, 64'(got[50:0]), 64'(vt[i].msg));
      chk({vt[i].name, " par"}, 64'(got[62:51]), 64'(vt[i].par));
      chk({vt[i].name, " span"}, 64'(span), 64'd63);
      chk({vt[i].name, " rdy_low"}, 64'(rdy_low), 64'd12);
      chk({vt[i].name, " rdy_end"}, 64'(rdy_end), 64'd1);
`ifdef BCH_ENC_LAST_EN
      chk({vt[i].name, " last"}, 64'(lastv), 64'd1 << 62);
`endif
    end

    // random messages under random in/out throttling
    for (int f = 0; f < 6; f++) begin
      msg = {$urandom(), $urandom()};
      run_frame(msg, 40 + 10 * f, 90 - 10 * f, got, lastv, span, rdy_low, rdy_end, held_ok, done);
      chk("rnd done", 64'(done), 64'd1);
      chk("rnd msg", 64'(got[50:0]), 64'(msg));
      chk("rnd par", 64'(got[62:51]), 64'(par_of(msg)));
      chk("rnd syndrome", 64'(mod_g(got)), 64'd0);
      chk("rnd hold", 64'(held_ok), 64'd1);
`ifdef BCH_ENC_LAST_EN
      chk("rnd last", 64'(lastv), 64'd1 << 62);
`endif
    end

    // reset after 30 message bits, then a fresh frame
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      in_valid  = 1'b1;
      in_data   = 1'($urandom_range(1));
      out_ready = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst out_valid", 64'(out_valid), 64'd0);
    chk("midrst in_ready", 64'(in_ready), 64'd0);
    chk("midrst out_last", 64'(out_last), 64'd0);
    repeat (2) @(negedge clk);
    #1;
    chk("midrst out_valid held", 64'(out_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    msg = {$urandom(), $urandom()};
    run_frame(msg, 100, 100, got, lastv, span, rdy_low, rdy_end, held_ok, done);
    chk("post-rst done", 64'(done), 64'd1);
    chk("post-rst msg", 64'(got[50:0]), 64'(msg));
    chk("post-rst par", 64'(got[62:51]), 64'(par_of(msg)));
    chk("post-rst span", 64'(span), 64'd63);
`ifdef BCH_ENC_LAST_EN
    chk("post-rst last", 64'(lastv), 64'd1 << 62);
`endif

    @(negedge clk);
    in_valid = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
